// File: rtl/uart_receive.sv
// uart_receive: oversampled UART receiver with 2-flop synchronizer and break detection.
// Optional even parity check enabled by defining UART_RECEIVE_PARITY_EN.
module uart_receive #(
    parameter int D_WIDTH      = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_frame_err,
    output logic               rx_parity_err
);
    localparam logic [7:0] HALF      = 8'(CLKS_PER_BIT / 2);
    localparam logic [7:0] LAST      = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] BITS_LAST = 5'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RECEIVE_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;

    state_t             r_state;
    logic               r_sync1, r_sync2;
    logic [7:0]         r_cnt;
    logic [4:0]         r_bit;
    logic [D_WIDTH-1:0] r_shift, r_data;
    logic               r_valid, r_ferr;
    logic               w_tick;
`ifdef UART_RECEIVE_PARITY_EN
    logic               r_par_bad, r_perr;
`endif

    assign w_tick       = r_cnt == LAST;
    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_busy      = r_state != IDLE;
`ifdef UART_RECEIVE_PARITY_EN
    assign rx_parity_err = r_perr;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RECEIVE_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RECEIVE_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                IDLE: if (!r_sync2) begin
                    r_state <= START;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                end
                START: if (r_cnt == HALF) begin
                    r_cnt   <= '0;
                    r_state <= r_sync2 ? IDLE : DATA;
                end else r_cnt <= r_cnt + 8'd1;
                DATA: if (w_tick) begin
                    r_cnt   <= '0;
                    r_shift <= D_WIDTH'({r_sync2, r_shift} >> 1);
                    r_bit   <= r_bit + 5'd1;
`ifdef UART_RECEIVE_PARITY_EN
                    if (r_bit == BITS_LAST) r_state <= PARITY;
`else
                    if (r_bit == BITS_LAST) r_state <= STOP;
`endif
                end else r_cnt <= r_cnt + 8'd1;
`ifdef UART_RECEIVE_PARITY_EN
                PARITY: if (w_tick) begin
                    r_cnt     <= '0;
                    r_par_bad <= ^{r_sync2, r_shift};
                    r_state   <= STOP;
                end else r_cnt <= r_cnt + 8'd1;
`endif
                STOP: if (w_tick) begin
                    r_cnt <= '0;
                    if (r_sync2) begin
                        r_state <= IDLE;
`ifdef UART_RECEIVE_PARITY_EN
                        if (r_par_bad) r_perr <= 1'b1;
                        else begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
`else
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
`endif
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= BREAK;
                    end
                end else r_cnt <= r_cnt + 8'd1;
                BREAK: if (r_sync2) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
